// File: rtl/sys_defs.sv
// Shared memory-interface types used by the fetch/dcache side and the memory arbiter.
package sys_defs;

  typedef logic [31:0] ADDR;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [3:0]  MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } MEM_REQUESTER;

  typedef struct packed {
    logic         valid;
    MEM_REQUESTER owner;
  } MEM_OWNER_ENTRY;

endpackage

// File: rtl/mem_tag_table.sv
// Owner table for in-flight memory load tags: one write port, one clear port,
// one lookup port. A write to the same tag as a clear in the same cycle wins.
module mem_tag_table
  import sys_defs::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           wr_en,
  input  MEM_TAG         wr_tag,
  input  MEM_REQUESTER   wr_owner,
  input  logic           clr_en,
  input  MEM_TAG         clr_tag,
  input  MEM_TAG         rd_tag,
  output MEM_OWNER_ENTRY rd_entry
);

  MEM_OWNER_ENTRY entries [NUM_TAGS];

  // Entry 0 is reserved ("no tag") and is never written after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        entries[i] <= '{valid: 1'b0, owner: REQ_IC};
      end
    end else begin
      for (int i = 1; i < NUM_TAGS; i++) begin
        if (wr_en && wr_tag == MEM_TAG'(i)) begin
          entries[i] <= '{valid: 1'b1, owner: wr_owner};
        end else if (clr_en && clr_tag == MEM_TAG'(i)) begin
          entries[i].valid <= 1'b0;
        end
      end
    end
  end

  // NUM_TAGS is expected to cover the full MEM_TAG range.
  assign rd_entry = entries[rd_tag];

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between the icache fill path and the dcache,
// tracks load-tag ownership and routes returned data back to its requester.
module mem_arbiter
  import sys_defs::*;
#(
  parameter int NUM_TAGS        = 16,
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ic_req_valid_i,
  input  ADDR        ic_req_addr_i,
  output logic       ic_req_accept_o,
  output MEM_TAG     ic_req_tag_o,
  output logic       ic_resp_valid_o,
  output MEM_TAG     ic_resp_tag_o,
  output MEM_BLOCK   ic_resp_data_o,
  input  logic       dc_req_valid_i,
  input  MEM_COMMAND dc_req_cmd_i,
  input  ADDR        dc_req_addr_i,
  input  MEM_BLOCK   dc_req_data_i,
  output logic       dc_req_accept_o,
  output MEM_TAG     dc_req_tag_o,
  output logic       dc_resp_valid_o,
  output MEM_TAG     dc_resp_tag_o,
  output MEM_BLOCK   dc_resp_data_o,
  output MEM_COMMAND proc2mem_command_o,
  output ADDR        proc2mem_addr_o,
  output MEM_BLOCK   proc2mem_data_o,
  input  MEM_TAG     mem2proc_transaction_tag_i,
  input  MEM_BLOCK   mem2proc_data_i,
  input  MEM_TAG     mem2proc_data_tag_i,
  output logic       orphan_err_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [SW-1:0]  starve_cnt, starve_nxt;
  logic [OW-1:0]  ic_cnt, ic_cnt_nxt, dc_cnt, dc_cnt_nxt;
  logic           orphan_q;

  logic           ic_elig, dc_elig, dc_is_store;
  logic           ic_wins, dc_wins, mem_ok;
  logic           ic_accept, dc_accept, dc_load_accept;
  logic           resp_present, resp_hit, orphan;
  MEM_OWNER_ENTRY rd_entry;

  assign dc_is_store = (dc_req_cmd_i == MEM_STORE);
  assign ic_elig     = ic_req_valid_i && (ic_cnt < OW'(MAX_OUTSTANDING));
  // Stores never hold a tag, so the outstanding cap does not apply to them.
  assign dc_elig     = dc_req_valid_i && (dc_req_cmd_i != MEM_NONE) &&
                       (dc_is_store || (dc_cnt < OW'(MAX_OUTSTANDING)));

  assign ic_wins = ic_elig && (!dc_elig || (starve_cnt == SW'(STARVE_LIMIT)));
  assign dc_wins = dc_elig && !ic_wins;

  assign mem_ok         = (mem2proc_transaction_tag_i != '0);
  assign ic_accept      = ic_wins && mem_ok;
  assign dc_accept      = dc_wins && mem_ok;
  assign dc_load_accept = dc_accept && !dc_is_store;

  assign ic_req_accept_o = ic_accept;
  assign dc_req_accept_o = dc_accept;
  assign ic_req_tag_o    = mem2proc_transaction_tag_i;
  assign dc_req_tag_o    = mem2proc_transaction_tag_i;

  always_comb begin
    proc2mem_command_o = MEM_NONE;
    proc2mem_addr_o    = '0;
    proc2mem_data_o    = '0;
    if (ic_wins) begin
      proc2mem_command_o = MEM_LOAD;
      proc2mem_addr_o    = ic_req_addr_i;
    end else if (dc_wins) begin
      proc2mem_command_o = dc_req_cmd_i;
      proc2mem_addr_o    = dc_req_addr_i;
      proc2mem_data_o    = dc_req_data_i;
    end
  end

  mem_tag_table #(.NUM_TAGS(NUM_TAGS)) u_tag_table (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (ic_accept || dc_load_accept),
    .wr_tag   (mem2proc_transaction_tag_i),
    .wr_owner (ic_wins ? REQ_IC : REQ_DC),
    .clr_en   (resp_hit),
    .clr_tag  (mem2proc_data_tag_i),
    .rd_tag   (mem2proc_data_tag_i),
    .rd_entry (rd_entry)
  );

  assign resp_present = (mem2proc_data_tag_i != '0);
  assign resp_hit     = resp_present && rd_entry.valid;
  assign orphan       = resp_present && !rd_entry.valid;

  assign ic_resp_valid_o = resp_hit && (rd_entry.owner == REQ_IC);
  assign dc_resp_valid_o = resp_hit && (rd_entry.owner == REQ_DC);
  assign ic_resp_tag_o   = ic_resp_valid_o ? mem2proc_data_tag_i : '0;
  assign dc_resp_tag_o   = dc_resp_valid_o ? mem2proc_data_tag_i : '0;
  assign ic_resp_data_o  = ic_resp_valid_o ? mem2proc_data_i : '0;
  assign dc_resp_data_o  = dc_resp_valid_o ? mem2proc_data_i : '0;
  assign orphan_err_o    = orphan_q;

  always_comb begin
    ic_cnt_nxt = ic_cnt;
    if (ic_accept && !ic_resp_valid_o)      ic_cnt_nxt = ic_cnt + 1'b1;
    else if (!ic_accept && ic_resp_valid_o) ic_cnt_nxt = ic_cnt - 1'b1;
  end

  always_comb begin
    dc_cnt_nxt = dc_cnt;
    if (dc_load_accept && !dc_resp_valid_o)      dc_cnt_nxt = dc_cnt + 1'b1;
    else if (!dc_load_accept && dc_resp_valid_o) dc_cnt_nxt = dc_cnt - 1'b1;
  end

  // An icache rejection holds the count so icache keeps its turn.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!ic_req_valid_i || ic_accept) begin
      starve_nxt = '0;
    end else if (ic_elig && dc_wins && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      ic_cnt     <= '0;
      dc_cnt     <= '0;
      orphan_q   <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      ic_cnt     <= ic_cnt_nxt;
      dc_cnt     <= dc_cnt_nxt;
      orphan_q   <= orphan_q | orphan;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration, starvation guard, tag routing and orphan detection.
module tb_mem_arbiter;
  import sys_defs::*;

  logic       clock, reset;
  logic       ic_req_valid_i;
  ADDR        ic_req_addr_i;
  logic       ic_req_accept_o;
  MEM_TAG     ic_req_tag_o;
  logic       ic_resp_valid_o;
  MEM_TAG     ic_resp_tag_o;
  MEM_BLOCK   ic_resp_data_o;
  logic       dc_req_valid_i;
  MEM_COMMAND dc_req_cmd_i;
  ADDR        dc_req_addr_i;
  MEM_BLOCK   dc_req_data_i;
  logic       dc_req_accept_o;
  MEM_TAG     dc_req_tag_o;
  logic       dc_resp_valid_o;
  MEM_TAG     dc_resp_tag_o;
  MEM_BLOCK   dc_resp_data_o;
  MEM_COMMAND proc2mem_command_o;
  ADDR        proc2mem_addr_o;
  MEM_BLOCK   proc2mem_data_o;
  MEM_TAG     mem2proc_transaction_tag_i;
  MEM_BLOCK   mem2proc_data_i;
  MEM_TAG     mem2proc_data_tag_i;
  logic       orphan_err_o;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clock                      (clock),
    .reset                      (reset),
    .ic_req_valid_i             (ic_req_valid_i),
    .ic_req_addr_i              (ic_req_addr_i),
    .ic_req_accept_o            (ic_req_accept_o),
    .ic_req_tag_o               (ic_req_tag_o),
    .ic_resp_valid_o            (ic_resp_valid_o),
    .ic_resp_tag_o              (ic_resp_tag_o),
    .ic_resp_data_o             (ic_resp_data_o),
    .dc_req_valid_i             (dc_req_valid_i),
    .dc_req_cmd_i               (dc_req_cmd_i),
    .dc_req_addr_i              (dc_req_addr_i),
    .dc_req_data_i              (dc_req_data_i),
    .dc_req_accept_o            (dc_req_accept_o),
    .dc_req_tag_o               (dc_req_tag_o),
    .dc_resp_valid_o            (dc_resp_valid_o),
    .dc_resp_tag_o              (dc_resp_tag_o),
    .dc_resp_data_o             (dc_resp_data_o),
    .proc2mem_command_o         (proc2mem_command_o),
    .proc2mem_addr_o            (proc2mem_addr_o),
    .proc2mem_data_o            (proc2mem_data_o),
    .mem2proc_transaction_tag_i (mem2proc_transaction_tag_i),
    .mem2proc_data_i            (mem2proc_data_i),
    .mem2proc_data_tag_i        (mem2proc_data_tag_i),
    .orphan_err_o               (orphan_err_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive_idle();
    ic_req_valid_i             = 1'b0;
    ic_req_addr_i              = '0;
    dc_req_valid_i             = 1'b0;
    dc_req_cmd_i               = MEM_NONE;
    dc_req_addr_i              = '0;
    dc_req_data_i              = '0;
    mem2proc_transaction_tag_i = '0;
    mem2proc_data_i            = '0;
    mem2proc_data_tag_i        = '0;
  endtask

  // Leaves the bench at a falling edge with reset released.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    drive_idle();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    drive_idle();
    #1;
    checks++; if (proc2mem_command_o !== MEM_NONE) begin errors++; $display("FAIL reset_cmd: got %0h expected %0h", proc2mem_command_o, MEM_NONE); end
    checks++; if (ic_req_accept_o !== 1'b0 || dc_req_accept_o !== 1'b0) begin errors++; $display("FAIL reset_accept: got ic=%0b dc=%0b expected 0 0", ic_req_accept_o, dc_req_accept_o); end
    checks++; if (ic_resp_valid_o !== 1'b0 || dc_resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_resp: got ic=%0b dc=%0b expected 0 0", ic_resp_valid_o, dc_resp_valid_o); end
    checks++; if (orphan_err_o !== 1'b0) begin errors++; $display("FAIL reset_orphan: got %0b expected 0", orphan_err_o); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_ic_only();
    do_reset();
    ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h100; mem2proc_transaction_tag_i = 4'd3;
    #1;
    checks++; if (ic_req_accept_o !== 1'b1) begin errors++; $display("FAIL ic_only_accept: got %0b expected 1", ic_req_accept_o); end
    checks++; if (ic_req_tag_o !== 4'd3) begin errors++; $display("FAIL ic_only_tag: got %0d expected 3", ic_req_tag_o); end
    checks++; if (proc2mem_command_o !== MEM_LOAD || proc2mem_addr_o !== 32'h100) begin errors++; $display("FAIL ic_only_drive: got cmd=%0h addr=%0h expected 1 100", proc2mem_command_o, proc2mem_addr_o); end
    @(negedge clock); drive_idle();
    repeat (4) @(negedge clock);
    mem2proc_data_tag_i = 4'd3; mem2proc_data_i = 64'hDEAD_BEEF_0123_4567;
    #1;
    checks++; if (ic_resp_valid_o !== 1'b1 || ic_resp_tag_o !== 4'd3) begin errors++; $display("FAIL ic_only_resp: got valid=%0b tag=%0d expected 1 3", ic_resp_valid_o, ic_resp_tag_o); end
    checks++; if (ic_resp_data_o !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL ic_only_data: got %0h expected deadbeef01234567", ic_resp_data_o); end
    checks++; if (dc_resp_valid_o !== 1'b0) begin errors++; $display("FAIL ic_only_dc_resp: got %0b expected 0", dc_resp_valid_o); end
    @(negedge clock); drive_idle();
    mem2proc_data_tag_i = 4'd3;
    #1;
    checks++; if (ic_resp_valid_o !== 1'b0) begin errors++; $display("FAIL ic_only_cleared: got %0b expected 0", ic_resp_valid_o); end
    @(negedge clock); drive_idle();
    #1;
    checks++; if (orphan_err_o !== 1'b1) begin errors++; $display("FAIL ic_only_second_return_orphan: got %0b expected 1", orphan_err_o); end
  endtask

  task automatic test_both_load();
    do_reset();
    ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h200;
    dc_req_valid_i = 1'b1; dc_req_cmd_i = MEM_LOAD; dc_req_addr_i = 32'h340;
    mem2proc_transaction_tag_i = 4'd5;
    #1;
    checks++; if (dc_req_accept_o !== 1'b1 || dc_req_tag_o !== 4'd5) begin errors++; $display("FAIL both_dc_accept: got acc=%0b tag=%0d expected 1 5", dc_req_accept_o, dc_req_tag_o); end
    checks++; if (proc2mem_addr_o !== 32'h340) begin errors++; $display("FAIL both_addr: got %0h expected 340", proc2mem_addr_o); end
    checks++; if (ic_req_accept_o !== 1'b0) begin errors++; $display("FAIL both_ic_accept: got %0b expected 0", ic_req_accept_o); end
    @(negedge clock); drive_idle();
  endtask

  task automatic test_starvation();
    logic exp_ic;
    do_reset();
    ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h400;
    dc_req_valid_i = 1'b1; dc_req_cmd_i = MEM_LOAD; dc_req_addr_i = 32'h500;
    for (int c = 1; c <= 7; c++) begin
      mem2proc_transaction_tag_i = MEM_TAG'(c);
      exp_ic = (c == 5);
      #1;
      checks++; if (ic_req_accept_o !== exp_ic || dc_req_accept_o !== !exp_ic) begin errors++; $display("FAIL starve_cycle%0d: got ic=%0b dc=%0b expected ic=%0b dc=%0b", c, ic_req_accept_o, dc_req_accept_o, exp_ic, !exp_ic); end
      @(negedge clock);
    end
    drive_idle();
  endtask

  task automatic test_reject_hold();
    do_reset();
    ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h440;
    dc_req_valid_i = 1'b1; dc_req_cmd_i = MEM_LOAD; dc_req_addr_i = 32'h550;
    for (int c = 1; c <= 4; c++) begin
      mem2proc_transaction_tag_i = MEM_TAG'(c);
      @(negedge clock);
    end
    mem2proc_transaction_tag_i = '0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++; if (ic_req_accept_o !== 1'b0 || dc_req_accept_o !== 1'b0) begin errors++; $display("FAIL reject_accept%0d: got ic=%0b dc=%0b expected 0 0", c, ic_req_accept_o, dc_req_accept_o); end
      checks++; if (proc2mem_addr_o !== 32'h440) begin errors++; $display("FAIL reject_hold_ic%0d: got addr=%0h expected 440", c, proc2mem_addr_o); end
      @(negedge clock);
    end
    mem2proc_transaction_tag_i = 4'd7;
    #1;
    checks++; if (ic_req_accept_o !== 1'b1 || ic_req_tag_o !== 4'd7) begin errors++; $display("FAIL reject_then_accept: got acc=%0b tag=%0d expected 1 7", ic_req_accept_o, ic_req_tag_o); end
    @(negedge clock); drive_idle();
  endtask

  task automatic test_store_orphan();
    do_reset();
    dc_req_valid_i = 1'b1; dc_req_cmd_i = MEM_STORE; dc_req_addr_i = 32'h600;
    dc_req_data_i = 64'h0000_0000_0000_CAFE; mem2proc_transaction_tag_i = 4'd9;
    #1;
    checks++; if (dc_req_accept_o !== 1'b1 || proc2mem_command_o !== MEM_STORE) begin errors++; $display("FAIL store_accept: got acc=%0b cmd=%0h expected 1 2", dc_req_accept_o, proc2mem_command_o); end
    checks++; if (proc2mem_data_o !== 64'hCAFE) begin errors++; $display("FAIL store_data: got %0h expected cafe", proc2mem_data_o); end
    @(negedge clock); drive_idle();
    mem2proc_data_tag_i = 4'd9; mem2proc_data_i = 64'h1234;
    #1;
    checks++; if (dc_resp_valid_o !== 1'b0 || ic_resp_valid_o !== 1'b0) begin errors++; $display("FAIL store_no_resp: got dc=%0b ic=%0b expected 0 0", dc_resp_valid_o, ic_resp_valid_o); end
    checks++; if (orphan_err_o !== 1'b0) begin errors++; $display("FAIL store_orphan_early: got %0b expected 0", orphan_err_o); end
    @(negedge clock); drive_idle();
    #1;
    checks++; if (orphan_err_o !== 1'b1) begin errors++; $display("FAIL store_orphan_set: got %0b expected 1", orphan_err_o); end
    @(negedge clock);
    #1;
    checks++; if (orphan_err_o !== 1'b1) begin errors++; $display("FAIL store_orphan_sticky: got %0b expected 1", orphan_err_o); end
  endtask

  task automatic test_outstanding();
    do_reset();
    ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h700;
    for (int c = 1; c <= 8; c++) begin
      mem2proc_transaction_tag_i = MEM_TAG'(c);
      #1;
      checks++; if (ic_req_accept_o !== 1'b1) begin errors++; $display("FAIL outst_fill%0d: got %0b expected 1", c, ic_req_accept_o); end
      @(negedge clock);
    end
    dc_req_valid_i = 1'b1; dc_req_cmd_i = MEM_LOAD; dc_req_addr_i = 32'h800;
    mem2proc_transaction_tag_i = 4'd9;
    #1;
    checks++; if (ic_req_accept_o !== 1'b0 || dc_req_accept_o !== 1'b1) begin errors++; $display("FAIL outst_dc_served: got ic=%0b dc=%0b expected 0 1", ic_req_accept_o, dc_req_accept_o); end
    checks++; if (proc2mem_addr_o !== 32'h800) begin errors++; $display("FAIL outst_dc_addr: got %0h expected 800", proc2mem_addr_o); end
    @(negedge clock);
    dc_req_valid_i = 1'b0; dc_req_cmd_i = MEM_NONE;
    mem2proc_transaction_tag_i = 4'd10; mem2proc_data_tag_i = 4'd1; mem2proc_data_i = 64'h11;
    #1;
    checks++; if (ic_req_accept_o !== 1'b0 || proc2mem_command_o !== MEM_NONE) begin errors++; $display("FAIL outst_ineligible: got acc=%0b cmd=%0h expected 0 0", ic_req_accept_o, proc2mem_command_o); end
    checks++; if (ic_resp_valid_o !== 1'b1) begin errors++; $display("FAIL outst_resp1: got %0b expected 1", ic_resp_valid_o); end
    @(negedge clock);
    mem2proc_transaction_tag_i = 4'd11; mem2proc_data_tag_i = 4'd2;
    #1;
    checks++; if (ic_req_accept_o !== 1'b1 || ic_resp_valid_o !== 1'b1) begin errors++; $display("FAIL outst_restored: got acc=%0b resp=%0b expected 1 1", ic_req_accept_o, ic_resp_valid_o); end
    @(negedge clock);
    mem2proc_transaction_tag_i = 4'd12; mem2proc_data_tag_i = '0;
    #1;
    checks++; if (ic_req_accept_o !== 1'b1) begin errors++; $display("FAIL outst_count_held: got %0b expected 1", ic_req_accept_o); end
    @(negedge clock);
    mem2proc_transaction_tag_i = 4'd13;
    #1;
    checks++; if (ic_req_accept_o !== 1'b0) begin errors++; $display("FAIL outst_full_again: got %0b expected 0", ic_req_accept_o); end
    @(negedge clock); drive_idle();
  endtask

  task automatic test_reissue();
    do_reset();
    ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h900; mem2proc_transaction_tag_i = 4'd5;
    @(negedge clock); drive_idle();
    dc_req_valid_i = 1'b1; dc_req_cmd_i = MEM_LOAD; dc_req_addr_i = 32'hA00;
    mem2proc_transaction_tag_i = 4'd5; mem2proc_data_tag_i = 4'd5; mem2proc_data_i = 64'h55;
    #1;
    checks++; if (ic_resp_valid_o !== 1'b1 || dc_req_accept_o !== 1'b1) begin errors++; $display("FAIL reissue_same_cycle: got ic_resp=%0b dc_acc=%0b expected 1 1", ic_resp_valid_o, dc_req_accept_o); end
    @(negedge clock); drive_idle();
    mem2proc_data_tag_i = 4'd5; mem2proc_data_i = 64'h66;
    #1;
    checks++; if (dc_resp_valid_o !== 1'b1 || ic_resp_valid_o !== 1'b0 || dc_resp_tag_o !== 4'd5) begin errors++; $display("FAIL reissue_new_owner: got dc=%0b ic=%0b tag=%0d expected 1 0 5", dc_resp_valid_o, ic_resp_valid_o, dc_resp_tag_o); end
    @(negedge clock); drive_idle();
    #1;
    checks++; if (orphan_err_o !== 1'b0) begin errors++; $display("FAIL reissue_no_orphan: got %0b expected 0", orphan_err_o); end
  endtask

  task automatic test_midop_reset();
    do_reset();
    ic_req_valid_i = 1'b1; ic_req_addr_i = 32'hB00; mem2proc_transaction_tag_i = 4'd4;
    @(negedge clock); drive_idle();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    mem2proc_data_tag_i = 4'd4; mem2proc_data_i = 64'h44;
    #1;
    checks++; if (ic_resp_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_no_resp: got %0b expected 0", ic_resp_valid_o); end
    @(negedge clock); drive_idle();
    #1;
    checks++; if (orphan_err_o !== 1'b1) begin errors++; $display("FAIL midreset_orphan: got %0b expected 1", orphan_err_o); end
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_ic_only();
    test_both_load();
    test_starvation();
    test_reject_hold();
    test_store_orphan();
    test_outstanding();
    test_reissue();
    test_midop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
